// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch PC generator and IF/ID pipeline register.
// Define IF_PERF_CNT_EN to build the delivered-instruction counter on fetch_count.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,     pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q,  instr_d;
    logic        valid_q,  valid_d;
    logic [31:0] pc_plus4;
    logic        capture;

    assign pc_plus4 = pc_q + 32'd4;
    // A real instruction is delivered only when neither redirect nor stall applies.
    assign capture  = !branch_taken && !freeze;

    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (branch_taken) begin
            pc_d     = {branch_addr[31:2], 2'b00};
            pc_out_d = '0;
            instr_d  = '0;
            valid_d  = 1'b0;
        end else if (!freeze) begin
            pc_d     = pc_plus4;
            pc_out_d = pc_plus4;
            instr_d  = imem_instr;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (capture) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign fetch_count = cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign fetch_count    = '0;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'd0, PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 freeze  input  1  hazard stall from the hazard unit; hold PC and the IF/ID register.
REQ-005 branch_taken  input  1  branch resolved taken in EX; redirect PC and flush IF/ID.
REQ-006 branch_addr  input  32  branch target byte address.
REQ-007 imem_addr  output  32  byte address to the instruction memory; SHALL equal PC combinationally.
REQ-008 imem_instr  input  32  instruction word returned combinationally by the instruction memory for imem_addr.
REQ-009 pc_out  output  32  registered PC+4 of the captured instruction, to ID.
REQ-010 instr_out  output  32  registered instruction word, to ID.
REQ-011 valid_out  output  1  registered; 1 = instr_out holds a real fetched instruction, 0 = bubble.
REQ-012 fetch_count  output  32  count of instructions delivered to ID; see Configuration.

Function
REQ-013 PC update priority, evaluated per rising edge: reset > branch_taken > freeze > increment.
REQ-014 branch_taken=1: PC <= {branch_addr[31:2],2'b00}; freeze SHALL be ignored that cycle.
REQ-015 freeze=1 and branch_taken=0: PC holds its value.
REQ-016 Neither asserted: PC <= PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000 with no flag).
REQ-017 IF/ID on branch_taken=1 (flush): instr_out <= 0, pc_out <= 0, valid_out <= 0.
REQ-018 IF/ID on freeze=1 and branch_taken=0: instr_out, pc_out and valid_out hold.
REQ-019 IF/ID otherwise: instr_out <= imem_instr, pc_out <= PC+4 (same wrap rule), valid_out <= 1.
REQ-020 Latency: the word at address A SHALL appear on instr_out one edge after imem_addr=A is presented and not frozen.
REQ-021 A 32'h0 word on instr_out with valid_out=1 is a legal fetched word; consumers SHALL use valid_out, not the word value, to detect bubbles.
REQ-022 There SHALL be no combinational path from freeze, branch_taken or branch_addr to any output.

Reset
REQ-023 rst=0 at an edge: PC <= RESET_PC; instr_out, pc_out and valid_out <= 0; fetch_count <= 0; this overrides freeze and branch_taken.
REQ-024 First edge with rst=1 and no freeze/branch: IF/ID SHALL capture the word at RESET_PC with pc_out=RESET_PC+4 and valid_out=1.
REQ-025 Reset asserted mid-stall or mid-branch SHALL discard the pending redirect or stall completely.

Configuration
REQ-026 Macro IF_PERF_CNT_EN defined: fetch_count SHALL increment by 1 on every edge where REQ-019 applies, wrap modulo 2^32, and hold otherwise.
REQ-027 Macro IF_PERF_CNT_EN undefined: fetch_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-028 Reset at PC=0, then 2 free-running edges with the standard program image -> instr_out=E3A00014/pc_out=4, then instr_out=E3A01A01/pc_out=8, valid_out=1, fetch_count=2 (with macro).
REQ-029 freeze=1 for 2 edges while imem_addr=8 -> imem_addr stays 8 and instr_out/pc_out/valid_out unchanged; after release, next edge captures the word at address 8 with pc_out=12.
REQ-030 branch_taken=1, branch_addr=0x70, freeze=1 on the same edge -> imem_addr=0x70, instr_out=0, valid_out=0, fetch_count unchanged; next edge pc_out=0x74, valid_out=1.
REQ-031 branch_addr=0x93 -> imem_addr=0x90 (low bits cleared).
REQ-032 RESET_PC=0xFFFFFFFC, one free edge after reset -> imem_addr=0x00000000 and pc_out=0x00000000.
REQ-033 rst=0 with PC=0x40, freeze=1 and branch_taken=1 -> after the edge imem_addr=RESET_PC, all registered outputs 0, fetch_count=0; without the macro, fetch_count=0 in all scenarios.
